// File: rtl/ln_row_stats_accumulate.sv
// ln_row_stats_accumulate: per-beat adder-tree reduction and per-bank row sum / sum-of-squares accumulation.
// Define LN_PARTIAL_OUT_EN to expose the per-beat tree output ports.
module ln_row_stats_accumulate #(
  parameter int LANES = 64,
  parameter int DATA_W = 16,
  parameter int BEATS = 12,
  parameter int NUM_BANKS = 4,
  parameter int SUM_W = DATA_W + $clog2(LANES*BEATS),
  parameter int SQ_W = 2*DATA_W + $clog2(LANES*BEATS)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_valid,
  input  logic [LANES*DATA_W-1:0] i_data_flat,
  input  logic [$clog2(NUM_BANKS)-1:0] i_ptr_in,
  input  logic [3:0] i_cycle_cnt,
  output logic o_row_valid,
  output logic [$clog2(NUM_BANKS)-1:0] o_row_ptr,
  output logic signed [SUM_W-1:0] o_row_sum,
  output logic signed [SQ_W-1:0] o_row_sq_sum,
  output logic o_seq_err,
  output logic [$clog2(NUM_BANKS)-1:0] o_err_ptr
`ifdef LN_PARTIAL_OUT_EN
  ,
  output logic o_part_valid,
  output logic [$clog2(NUM_BANKS)-1:0] o_part_ptr,
  output logic [3:0] o_part_cnt,
  output logic signed [DATA_W+$clog2(LANES)-1:0] o_part_sum,
  output logic signed [2*DATA_W+$clog2(LANES)-1:0] o_part_sq_sum
`endif
);
  localparam int L = $clog2(LANES);
  localparam int PTR_W = $clog2(NUM_BANKS);
  localparam int PW = DATA_W + L;
  localparam int QW = 2*DATA_W + L;
  localparam logic [4:0] BEATS_C = 5'(BEATS);
  logic signed [DATA_W-1:0] lane [LANES];
  logic signed [DATA_W-1:0] s0_d [LANES];
  logic signed [2*DATA_W-1:0] s0_q [LANES];
  logic s0_v;
  logic [PTR_W-1:0] s0_p;
  logic [3:0] s0_c;
  for (genvar n = 0; n < LANES; n++) begin : unpack
    assign lane[n] = i_data_flat[n*DATA_W +: DATA_W];
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      s0_v <= 1'b0;
      s0_p <= '0;
      s0_c <= '0;
      for (int i = 0; i < LANES; i++) begin
        s0_d[i] <= '0;
        s0_q[i] <= '0;
      end
    end else if (i_en) begin
      s0_v <= i_valid;
      s0_p <= i_ptr_in;
      s0_c <= i_cycle_cnt;
      for (int i = 0; i < LANES; i++) begin
        s0_d[i] <= lane[i];
        s0_q[i] <= (2*DATA_W)'(lane[i]) * (2*DATA_W)'(lane[i]);
      end
    end
  // Level g halves the operand count and grows each word by one sign bit.
  for (genvar g = 0; g < L; g++) begin : lvl
    localparam int N = LANES >> (g + 1);
    logic signed [DATA_W+g:0] s [N];
    logic signed [2*DATA_W+g:0] q [N];
    logic v;
    logic [PTR_W-1:0] p;
    logic [3:0] c;
    logic signed [DATA_W+g-1:0] as [2*N];
    logic signed [2*DATA_W+g-1:0] aq [2*N];
    logic av;
    logic [PTR_W-1:0] ap;
    logic [3:0] ac;
    if (g == 0) begin : src
      assign as = s0_d;
      assign aq = s0_q;
      assign av = s0_v;
      assign ap = s0_p;
      assign ac = s0_c;
    end else begin : src
      assign as = lvl[g-1].s;
      assign aq = lvl[g-1].q;
      assign av = lvl[g-1].v;
      assign ap = lvl[g-1].p;
      assign ac = lvl[g-1].c;
    end
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        v <= 1'b0;
        p <= '0;
        c <= '0;
        for (int i = 0; i < N; i++) begin
          s[i] <= '0;
          q[i] <= '0;
        end
      end else if (i_en) begin
        v <= av;
        p <= ap;
        c <= ac;
        for (int i = 0; i < N; i++) begin
          s[i] <= (DATA_W+g+1)'(as[2*i]) + (DATA_W+g+1)'(as[2*i+1]);
          q[i] <= (2*DATA_W+g+1)'(aq[2*i]) + (2*DATA_W+g+1)'(aq[2*i+1]);
        end
      end
  end
  logic signed [PW-1:0] t_s;
  logic signed [QW-1:0] t_q;
  logic t_v;
  logic [PTR_W-1:0] t_p;
  logic [3:0] t_c;
  assign t_s = lvl[L-1].s[0];
  assign t_q = lvl[L-1].q[0];
  assign t_v = lvl[L-1].v;
  assign t_p = lvl[L-1].p;
  assign t_c = lvl[L-1].c;
`ifdef LN_PARTIAL_OUT_EN
  assign o_part_valid = t_v;
  assign o_part_ptr = t_p;
  assign o_part_cnt = t_c;
  assign o_part_sum = t_s;
  assign o_part_sq_sum = t_q;
`endif
  logic signed [SUM_W-1:0] acc_s [NUM_BANKS];
  logic signed [SQ_W-1:0] acc_q [NUM_BANKS];
  logic [3:0] exp_c [NUM_BANKS];
  logic ok, done, err;
  logic signed [SUM_W-1:0] nxt_s;
  logic signed [SQ_W-1:0] nxt_q;
  // cnt==0 always opens a row; any other index must match the bank's expected beat.
  always_comb begin
    ok = t_c == 4'd0 || ({1'b0, t_c} < BEATS_C && t_c == exp_c[t_p]);
    done = ok && {1'b0, t_c} == BEATS_C - 5'd1;
    err = t_v && (!ok || (t_c == 4'd0 && exp_c[t_p] != 4'd0));
    nxt_s = (t_c == 4'd0 ? '0 : acc_s[t_p]) + SUM_W'(t_s);
    nxt_q = (t_c == 4'd0 ? '0 : acc_q[t_p]) + SQ_W'(t_q);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        acc_s[b] <= '0;
        acc_q[b] <= '0;
        exp_c[b] <= '0;
      end
      o_row_valid <= 1'b0;
      o_row_ptr <= '0;
      o_row_sum <= '0;
      o_row_sq_sum <= '0;
      o_seq_err <= 1'b0;
      o_err_ptr <= '0;
    end else if (!i_en) begin
      o_row_valid <= 1'b0;
      o_seq_err <= 1'b0;
    end else begin
      o_row_valid <= t_v && done;
      o_seq_err <= err;
      if (err) o_err_ptr <= t_p;
      if (t_v) begin
        if (ok) begin
          acc_s[t_p] <= nxt_s;
          acc_q[t_p] <= nxt_q;
        end
        exp_c[t_p] <= done ? 4'd0 : ok ? t_c + 4'd1 : 4'd0;
        if (done) begin
          o_row_ptr <= t_p;
          o_row_sum <= nxt_s;
          o_row_sq_sum <= nxt_q;
        end
      end
    end
endmodule

// File: tb/tb_ln_row_stats_accumulate.sv
// tb_ln_row_stats_accumulate: scoreboard bench for rows, sequence errors and optional partial outputs.
module tb_ln_row_stats_accumulate;
  localparam int LANES = 64, DATA_W = 16, BEATS = 12, NUM_BANKS = 4;
  localparam int SUM_W = 26, SQ_W = 42, PTR_W = 2;
  localparam int PART_LAT = 7, ROW_LAT = 8;
  typedef logic [LANES*DATA_W-1:0] vec_t;
  typedef struct {int p; int c; longint s; longint q; longint t;} ent_t;
  logic i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b0, i_valid = 1'b0;
  vec_t i_data_flat = '0;
  logic [PTR_W-1:0] i_ptr_in = '0;
  logic [3:0] i_cycle_cnt = '0;
  logic o_row_valid, o_seq_err;
  logic [PTR_W-1:0] o_row_ptr, o_err_ptr;
  logic signed [SUM_W-1:0] o_row_sum;
  logic signed [SQ_W-1:0] o_row_sq_sum;
`ifdef LN_PARTIAL_OUT_EN
  logic o_part_valid;
  logic [PTR_W-1:0] o_part_ptr;
  logic [3:0] o_part_cnt;
  logic signed [DATA_W+5:0] o_part_sum;
  logic signed [2*DATA_W+5:0] o_part_sq_sum;
`endif
  ent_t row_q[$], err_q[$], part_q[$];
  int total = 0, bad = 0;
  longint ecyc = 0, last_sum = 0;
  longint bexp[NUM_BANKS], bs[NUM_BANKS], bq[NUM_BANKS];
  logic en_q = 1'b0;
  always #5 i_clk = ~i_clk;
  ln_row_stats_accumulate dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
    .i_data_flat(i_data_flat), .i_ptr_in(i_ptr_in), .i_cycle_cnt(i_cycle_cnt),
    .o_row_valid(o_row_valid), .o_row_ptr(o_row_ptr), .o_row_sum(o_row_sum),
    .o_row_sq_sum(o_row_sq_sum), .o_seq_err(o_seq_err), .o_err_ptr(o_err_ptr)
`ifdef LN_PARTIAL_OUT_EN
    , .o_part_valid(o_part_valid), .o_part_ptr(o_part_ptr), .o_part_cnt(o_part_cnt),
    .o_part_sum(o_part_sum), .o_part_sq_sum(o_part_sq_sum)
`endif
  );
  task chk(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  function automatic vec_t fill(input int v);
    vec_t r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = v[DATA_W-1:0];
    return r;
  endfunction
  function automatic vec_t rnd();
    vec_t r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction
  task model_clear();
    row_q.delete();
    err_q.delete();
    part_q.delete();
    last_sum = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bexp[b] = 0;
      bs[b] = 0;
      bq[b] = 0;
    end
  endtask
  task beat(input int p, input int c, input vec_t d);
    longint s, q, v;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_ptr_in = p[PTR_W-1:0];
    i_cycle_cnt = c[3:0];
    i_data_flat = d;
    s = 0;
    q = 0;
    for (int i = 0; i < LANES; i++) begin
      v = longint'($signed(d[i*DATA_W +: DATA_W]));
      s += v;
      q += v * v;
    end
    part_q.push_back('{p, c, s, q, ecyc + PART_LAT});
    if (c == 0) begin
      if (bexp[p] != 0) err_q.push_back('{p, c, 0, 0, ecyc + ROW_LAT});
      bs[p] = s;
      bq[p] = q;
      bexp[p] = 1;
    end else if (c < BEATS && c == bexp[p]) begin
      bs[p] += s;
      bq[p] += q;
      bexp[p]++;
      if (c == BEATS - 1) begin
        row_q.push_back('{p, c, bs[p], bq[p], ecyc + ROW_LAT});
        bexp[p] = 0;
      end
    end else begin
      err_q.push_back('{p, c, 0, 0, ecyc + ROW_LAT});
      bexp[p] = 0;
    end
  endtask
  task idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_valid = 1'b0;
    end
  endtask
  task chk_zero(input string tag);
    chk({tag, "_rv"}, o_row_valid, 0);
    chk({tag, "_rp"}, o_row_ptr, 0);
    chk({tag, "_rs"}, o_row_sum, 0);
    chk({tag, "_rq"}, o_row_sq_sum, 0);
    chk({tag, "_se"}, o_seq_err, 0);
    chk({tag, "_ep"}, o_err_ptr, 0);
`ifdef LN_PARTIAL_OUT_EN
    chk({tag, "_pv"}, o_part_valid, 0);
    chk({tag, "_ps"}, o_part_sum, 0);
`endif
  endtask
  always @(posedge i_clk) begin
    en_q <= i_en && !i_rst;
    if (!i_rst && i_en) ecyc <= ecyc + 1;
  end
  always @(negedge i_clk) if (!i_rst) begin
    ent_t e;
    if (o_row_valid) begin
      if (row_q.size() == 0) chk("row_extra", 1, 0);
      else begin
        e = row_q.pop_front();
        chk("row_ptr", o_row_ptr, e.p);
        chk("row_sum", o_row_sum, e.s);
        chk("row_sq", o_row_sq_sum, e.q);
        chk("row_lat", ecyc, e.t);
        last_sum = e.s;
      end
    end
    if (o_seq_err) begin
      if (err_q.size() == 0) chk("err_extra", 1, 0);
      else begin
        e = err_q.pop_front();
        chk("err_ptr", o_err_ptr, e.p);
        chk("err_lat", ecyc, e.t);
      end
    end
    if (!i_en) chk("frz_sum", o_row_sum, last_sum);
`ifdef LN_PARTIAL_OUT_EN
    if (o_part_valid && en_q) begin
      if (part_q.size() == 0) chk("part_extra", 1, 0);
      else begin
        e = part_q.pop_front();
        chk("part_ptr", o_part_ptr, e.p);
        chk("part_cnt", o_part_cnt, e.c);
        chk("part_sum", o_part_sum, e.s);
        chk("part_sq", o_part_sq_sum, e.q);
        chk("part_lat", ecyc, e.t);
      end
    end
`endif
  end
  initial begin
    int vals[NUM_BANKS];
    vals = '{1, -1, 2, -32768};
    model_clear();
    repeat (3) @(negedge i_clk);
    chk_zero("rst");
    i_rst = 1'b0;
    i_en = 1'b1;
    for (int k = 0; k < BEATS; k++) beat(0, k, fill(k));
    idle(12);
    for (int c = 0; c < BEATS; c++)
      for (int b = 0; b < NUM_BANKS; b++) beat(b, c, fill(vals[b]));
    idle(12);
    beat(1, 0, fill(1));
    beat(1, 1, fill(1));
    for (int k = 3; k < BEATS; k++) beat(1, k, fill(1));
    for (int k = 0; k < BEATS; k++) beat(1, k, fill(1));
    idle(12);
    for (int k = 0; k < 6; k++) beat(2, k, fill(1));
    for (int k = 0; k < BEATS; k++) beat(2, k, fill(1));
    idle(12);
    for (int k = 0; k < 6; k++) beat(0, k, fill(k));
    @(negedge i_clk);
    i_en = 1'b0;
    i_valid = 1'b1;
    i_cycle_cnt = 4'd0;
    i_data_flat = rnd();
    repeat (5) @(negedge i_clk);
    i_en = 1'b1;
    i_valid = 1'b0;
    for (int k = 6; k < BEATS; k++) beat(0, k, fill(k));
    idle(12);
    for (int k = 0; k < BEATS; k++) beat(3, k, rnd());
    idle(12);
    for (int k = 0; k < 5; k++) beat(1, k, fill(3));
    idle(2);
    i_rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    model_clear();
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < BEATS; k++) beat(1, k, fill(1));
    idle(20);
    chk("row_left", row_q.size(), 0);
    chk("err_left", err_q.size(), 0);
`ifdef LN_PARTIAL_OUT_EN
    chk("part_left", part_q.size(), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
